// File: rtl/mod_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : mod_video_timing
// Brief    : Raster timing generator: pixel position, delayed sync/DE strobes,
//            once-per-frame latch pulse and 8-bit frame counter.
// Revision : 1.0  initial release
// ============================================================================
module mod_video_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int PIPE_DELAY = 1
) (
  input  logic       in_pix_clk,
  input  logic       in_rst_n,
  output logic [9:0] out_pix_x,
  output logic [9:0] out_pix_y,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de,
  output logic       out_latch,
  output logic [7:0] out_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit bounds so a 1024-wide raster's sync end still compares correctly
  localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        c_SYNC_ON    = (SYNC_POL != 0);
  localparam logic        c_SYNC_OFF   = (SYNC_POL == 0);

  logic [9:0]            r_x;
  logic [9:0]            r_y;
  logic                  r_latch;
  logic [7:0]            r_frame;
  logic [PIPE_DELAY-1:0] r_hs_pipe;
  logic [PIPE_DELAY-1:0] r_vs_pipe;
  logic [PIPE_DELAY-1:0] r_de_pipe;

  logic [9:0]            w_x_nxt;
  logic [9:0]            w_y_nxt;
  logic                  w_x_wrap;
  logic                  w_latch_nxt;
  logic                  w_hs_lvl;
  logic                  w_vs_lvl;
  logic                  w_de;

  always_comb begin
    w_x_wrap    = ({1'b0, r_x} == c_H_LAST);
    w_x_nxt     = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt     = r_y;
    if (w_x_wrap) begin
      w_y_nxt = ({1'b0, r_y} == c_V_LAST) ? 10'd0 : r_y + 10'd1;
    end
    w_latch_nxt = (w_x_nxt == 10'd0) && ({1'b0, w_y_nxt} == c_V_ACT);
  end

  always_comb begin
    w_hs_lvl = c_SYNC_OFF;
    w_vs_lvl = c_SYNC_OFF;
    if (({1'b0, r_x} >= c_HS_START) && ({1'b0, r_x} < c_HS_END)) begin
      w_hs_lvl = c_SYNC_ON;
    end
    if (({1'b0, r_y} >= c_VS_START) && ({1'b0, r_y} < c_VS_END)) begin
      w_vs_lvl = c_SYNC_ON;
    end
    w_de = ({1'b0, r_x} < c_H_ACT) && ({1'b0, r_y} < c_V_ACT);
  end

  // Latch and frame count are registered from next-state so they align with the counter
  always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_latch <= 1'b0;
      r_frame <= 8'd0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_latch <= w_latch_nxt;
      if (w_latch_nxt) begin
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  generate
    if (PIPE_DELAY > 1) begin : g_pipe_multi
      always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          r_hs_pipe <= {PIPE_DELAY{c_SYNC_OFF}};
          r_vs_pipe <= {PIPE_DELAY{c_SYNC_OFF}};
          r_de_pipe <= '0;
        end else begin
          r_hs_pipe <= {r_hs_pipe[PIPE_DELAY-2:0], w_hs_lvl};
          r_vs_pipe <= {r_vs_pipe[PIPE_DELAY-2:0], w_vs_lvl};
          r_de_pipe <= {r_de_pipe[PIPE_DELAY-2:0], w_de};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          r_hs_pipe <= c_SYNC_OFF;
          r_vs_pipe <= c_SYNC_OFF;
          r_de_pipe <= 1'b0;
        end else begin
          r_hs_pipe <= w_hs_lvl;
          r_vs_pipe <= w_vs_lvl;
          r_de_pipe <= w_de;
        end
      end
    end
  endgenerate

  assign out_pix_x = r_x;
  assign out_pix_y = r_y;
  assign out_hsync = r_hs_pipe[PIPE_DELAY-1];
  assign out_vsync = r_vs_pipe[PIPE_DELAY-1];
  assign out_de    = r_de_pipe[PIPE_DELAY-1];
  assign out_latch = r_latch;
  assign out_frame = r_frame;

endmodule
`default_nettype wire

// File: doc/mod_video_timing.md
Name: mod_video_timing

Overview:
Generates the raster timing for the video pipeline: the current pixel position, the sync and data-enable strobes, a once-per-frame latch pulse and a frame counter. It sits directly upstream of mod_hex_display. Its position outputs drive in_pix_x/in_pix_y and its latch output drives in_latch. The sync and DE strobes are delayed so they stay aligned with the registered overlay stage downstream. Default timing is 640x480@60 with a 25.175 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high), applies to both syncs
PIPE_DELAY, 1, cycles from counter value to out_hsync/out_vsync/out_de; legal range 1..4

Ports:
in_pix_clk  input  1  pixel clock; all logic is on its rising edge
in_rst_n  input  1  asynchronous active-low reset
out_pix_x  output  10  horizontal counter, 0..H_TOTAL-1
out_pix_y  output  10  vertical counter, 0..V_TOTAL-1
out_hsync  output  1  horizontal sync, delayed PIPE_DELAY cycles
out_vsync  output  1  vertical sync, delayed PIPE_DELAY cycles
out_de  output  1  active-video enable, delayed PIPE_DELAY cycles
out_latch  output  1  one-cycle frame pulse at the start of vertical blanking
out_frame  output  8  frame counter

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default). Both totals must be ≤ 1024.
- Reset (in_rst_n low, asynchronous assert; release synchronous to in_pix_clk):
  - out_pix_x = 0, out_pix_y = 0, out_de = 0, out_latch = 0, out_frame = 0.
  - out_hsync = out_vsync = ~SYNC_POL (the inactive level).
  - Every delay-pipeline stage is also reset to these inactive values.
- Counters are free-running with no stall input. Each cycle x increments.
  - When x = H_TOTAL-1: x wraps to 0 and y increments.
  - When y = V_TOTAL-1 in that same wrap cycle: y wraps to 0.
  - out_pix_x/out_pix_y are the counter registers themselves, with zero latency.
- Decode, applied to the counter value (x, y):
  - hs = H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vs = V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491 by default). vs is line-based and changes at x = 0.
  - de = (x < H_ACTIVE) && (y < V_ACTIVE).
- Sync/DE latency:
  - out_de(t) = de(x(t-PIPE_DELAY), y(t-PIPE_DELAY)); out_hsync/out_vsync likewise.
  - The syncs are driven at SYNC_POL when asserted.
  - The delay is a shift register of depth PIPE_DELAY, and every output is a flop.
- Latch pulse:
  - out_latch = 1 in exactly those cycles where out_pix_x = 0 and out_pix_y = V_ACTIVE.
  - It is undelayed: one cycle per frame, aligned with the counter.
  - It is driven by a register decoded from next-state; there is no combinational path from the counters to the output.
- Frame counter:
  - out_frame increments by 1 in the same cycle out_latch rises, i.e. the new value is visible alongside the pulse.
  - It wraps 255 → 0.
- Reset mid-frame: all state returns to the reset values immediately. No partial latch pulse or sync glitch to the active level is permitted during reset. After release, the first latch occurs when the counter first reaches (0, V_ACTIVE).
- First frame after reset: the counter starts at (0,0), so the first visible line begins immediately. out_de first goes high PIPE_DELAY cycles after release.

Test Plan:
- Reset: hold in_rst_n low, default parameters -> out_pix_x=0, out_pix_y=0, out_de=0, out_hsync=out_vsync=1, out_latch=0, out_frame=0. Asserting reset asynchronously between clock edges forces the same values without waiting for an edge.
- Line wrap: run to x=799, y=0 -> next cycle x=0, y=1. At x=799, y=524 -> next cycle x=0, y=0.
- Horizontal timing, PIPE_DELAY=1:
  - out_hsync is low for exactly 96 consecutive cycles.
  - It first goes low the cycle after out_pix_x=656.
  - Per visible line, out_de is high for 640 cycles, starting the cycle after x=0.
- Vertical timing:
  - out_vsync is low for exactly 2×800 = 1600 cycles per frame, beginning one cycle after (x=0, y=490).
  - out_de high count per frame = 307200.
- Latch/frame:
  - Over 3 frames, out_latch pulses exactly 3 times, each a single cycle, with out_pix_x=0 and out_pix_y=480.
  - out_frame reads 1, 2, 3 at the pulses.
  - Preloading to frame 255 and running one further frame -> out_frame=0.
- Variants:
  - PIPE_DELAY=3 -> out_de/out_hsync edges shift exactly 2 cycles later than with PIPE_DELAY=1.
  - SYNC_POL=1 -> syncs idle low and pulse high.
  - Reset asserted at (x=300, y=200) then released -> the sequence restarts from (0,0) with no stray latch pulse.
